// File: rtl/alarm_time_editor_if.sv
// ----------------------------------------------------------------------------
// alarm_time_editor_if
//   Groups the control inputs and the alarm/edit outputs of alarm_time_editor.
//
//   Signal semantics: there is no valid/ready pair. Inputs are levels
//   (active_program_mode, saved) or single-cycle pulses (btn_field, btn_inc),
//   and each is sampled on every rising clock edge. Outputs are registered.
//   alarm_*, edit_*, field_sel and state_dbg are levels. button_activity,
//   edit_error and commit are high for exactly one cycle, in the cycle after
//   the input that caused them.
//
//   Modports:
//     slave  : editor side (receives the controls, drives the results)
//     master : stimulus side (drives the controls, observes the results)
//   state_dbg exposes the editor FSM state: 0 = IDLE, 1 = EDIT, 2 = DONE.
// ----------------------------------------------------------------------------
interface alarm_time_editor_if;
    logic       active_program_mode;
    logic       saved;
    logic       btn_field;
    logic       btn_inc;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic [4:0] edit_hours;
    logic [5:0] edit_minutes;
    logic       field_sel;
    logic       button_activity;
    logic       edit_error;
    logic       commit;
    logic [1:0] state_dbg;

    modport slave (
        input  active_program_mode, saved, btn_field, btn_inc,
        output alarm_hours, alarm_minutes, edit_hours, edit_minutes,
               field_sel, button_activity, edit_error, commit, state_dbg
    );

    modport master (
        output active_program_mode, saved, btn_field, btn_inc,
        input  alarm_hours, alarm_minutes, edit_hours, edit_minutes,
               field_sel, button_activity, edit_error, commit, state_dbg
    );
endinterface

// File: rtl/alarm_time_editor.sv
// ----------------------------------------------------------------------------
// alarm_time_editor
//   Edits a working copy of the alarm time (HH:MM) while program mode is
//   active, and commits it to the alarm register on a rising edge of saved.
//   Leaving program mode without a commit discards the working copy.
//
//   Ports:
//     clk    : system clock, everything on the rising edge
//     rst_n  : synchronous active-low reset
//     bus    : alarm_time_editor_if.slave
//              in : active_program_mode, saved, btn_field, btn_inc
//              out: alarm_hours/minutes (committed), edit_hours/minutes
//                   (working copy), field_sel (0 = hours, 1 = minutes),
//                   button_activity / edit_error / commit (1-cycle pulses),
//                   state_dbg (0 = IDLE, 1 = EDIT, 2 = DONE)
// ----------------------------------------------------------------------------
module alarm_time_editor #(
    parameter int HOURS_MAX     = 23,
    parameter int MINUTES_MAX   = 59,
    parameter int RESET_HOURS   = 7,
    parameter int RESET_MINUTES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alarm_time_editor_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] H_MAX   = 5'(HOURS_MAX);
    localparam logic [5:0] M_MAX   = 6'(MINUTES_MAX);
    localparam logic [4:0] H_RESET = 5'(RESET_HOURS);
    localparam logic [5:0] M_RESET = 6'(RESET_MINUTES);

    state_t     state_q, state_d;
    logic       saved_q, saved_d;
    logic [4:0] alarm_hours_q, alarm_hours_d;
    logic [5:0] alarm_minutes_q, alarm_minutes_d;
    logic [4:0] edit_hours_q, edit_hours_d;
    logic [5:0] edit_minutes_q, edit_minutes_d;
    logic       field_sel_q, field_sel_d;
    logic       button_activity_q, button_activity_d;
    logic       edit_error_q, edit_error_d;
    logic       commit_q, commit_d;

    logic       saved_rise;

    always_comb begin
        // Edge detect against last cycle's level; saved_q tracks saved in
        // every state so a level already high on entry never looks like a rise.
        saved_rise        = bus.saved & ~saved_q;
        saved_d           = bus.saved;

        state_d           = state_q;
        alarm_hours_d     = alarm_hours_q;
        alarm_minutes_d   = alarm_minutes_q;
        edit_hours_d      = edit_hours_q;
        edit_minutes_d    = edit_minutes_q;
        field_sel_d       = field_sel_q;
        button_activity_d = 1'b0;
        edit_error_d      = 1'b0;
        commit_d          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.active_program_mode) begin
                    edit_hours_d   = alarm_hours_q;
                    edit_minutes_d = alarm_minutes_q;
                    field_sel_d    = 1'b0;
                    state_d        = ST_EDIT;
                end
            end

            ST_EDIT: begin
                if (!bus.active_program_mode) begin
                    // Abort: the working copy falls back to the committed time.
                    edit_hours_d   = alarm_hours_q;
                    edit_minutes_d = alarm_minutes_q;
                    state_d        = ST_IDLE;
                end else if (saved_rise) begin
                    // Commit wins over any press in the same cycle, so the
                    // value stored is the one shown before that press.
                    alarm_hours_d   = edit_hours_q;
                    alarm_minutes_d = edit_minutes_q;
                    commit_d        = 1'b1;
                    state_d         = ST_DONE;
                end else if (bus.btn_field && bus.btn_inc) begin
                    edit_error_d = 1'b1;
                end else if (bus.btn_field) begin
                    field_sel_d       = ~field_sel_q;
                    button_activity_d = 1'b1;
                end else if (bus.btn_inc) begin
                    // Fields wrap independently; no carry between them.
                    if (field_sel_q) begin
                        edit_minutes_d = (edit_minutes_q >= M_MAX) ? 6'd0
                                                                   : edit_minutes_q + 6'd1;
                    end else begin
                        edit_hours_d = (edit_hours_q >= H_MAX) ? 5'd0
                                                               : edit_hours_q + 5'd1;
                    end
                    button_activity_d = 1'b1;
                end
            end

            ST_DONE: begin
                // Hold here until the mode drops so a still-asserted trigger
                // cannot cause a second commit.
                if (!bus.active_program_mode) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            saved_q           <= 1'b0;
            alarm_hours_q     <= H_RESET;
            alarm_minutes_q   <= M_RESET;
            edit_hours_q      <= H_RESET;
            edit_minutes_q    <= M_RESET;
            field_sel_q       <= 1'b0;
            button_activity_q <= 1'b0;
            edit_error_q      <= 1'b0;
            commit_q          <= 1'b0;
        end else begin
            state_q           <= state_d;
            saved_q           <= saved_d;
            alarm_hours_q     <= alarm_hours_d;
            alarm_minutes_q   <= alarm_minutes_d;
            edit_hours_q      <= edit_hours_d;
            edit_minutes_q    <= edit_minutes_d;
            field_sel_q       <= field_sel_d;
            button_activity_q <= button_activity_d;
            edit_error_q      <= edit_error_d;
            commit_q          <= commit_d;
        end
    end

    assign bus.alarm_hours     = alarm_hours_q;
    assign bus.alarm_minutes   = alarm_minutes_q;
    assign bus.edit_hours      = edit_hours_q;
    assign bus.edit_minutes    = edit_minutes_q;
    assign bus.field_sel       = field_sel_q;
    assign bus.button_activity = button_activity_q;
    assign bus.edit_error      = edit_error_q;
    assign bus.commit          = commit_q;
    assign bus.state_dbg       = state_q;

endmodule
